// File: rtl/rob_wb_arbiter.sv
// rtl/rob_wb_arbiter.sv - round-robin arbiter of execution-unit results onto two ROB write ports
module rob_wb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 5,
    parameter int DEST_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wb_stall,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DEST_W-1:0]   req_dest,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      wb0_en,
    output logic [TAG_W-1:0]          wb0_tag,
    output logic [DEST_W-1:0]         wb0_dest,
    output logic [DATA_W-1:0]         wb0_data,
    output logic                      wb1_en,
    output logic [TAG_W-1:0]          wb1_tag,
    output logic [DEST_W-1:0]         wb1_dest,
    output logic [DATA_W-1:0]         wb1_data,
    output logic [CNT_W-1:0]          contention_cnt,
    output logic                      err_dup_tag
);
    localparam int              IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W:0]  N_IDX   = (IDX_W+1)'(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0]  r_rr_ptr;
    logic              w_blocked;
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic [IDX_W-1:0]  w_idx_a;
    logic [IDX_W-1:0]  w_idx_b;
    logic [IDX_W:0]    w_sum;
    logic [3:0]        w_vcnt;
    logic [TAG_W-1:0]  w_tag_a;
    logic [TAG_W-1:0]  w_tag_b;
    logic [DEST_W-1:0] w_dest_a;
    logic [DEST_W-1:0] w_dest_b;
    logic [DATA_W-1:0] w_data_a;
    logic [DATA_W-1:0] w_data_b;
    logic              w_contended;

    assign w_blocked = wb_stall | flush;

    // Scan units starting at rr_ptr and grant the first two valid ones.
    always_comb begin
        w_gnt_a   = 1'b0;
        w_gnt_b   = 1'b0;
        w_idx_a   = '0;
        w_idx_b   = '0;
        w_sum     = '0;
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= N_IDX) begin
                w_sum = w_sum - N_IDX;
            end
            if (!w_blocked && req_valid[w_sum[IDX_W-1:0]]) begin
                if (!w_gnt_a) begin
                    w_gnt_a = 1'b1;
                    w_idx_a = w_sum[IDX_W-1:0];
                end else if (!w_gnt_b) begin
                    w_gnt_b = 1'b1;
                    w_idx_b = w_sum[IDX_W-1:0];
                end
            end
        end
        if (w_gnt_a) begin
            req_ready[w_idx_a] = 1'b1;
        end
        if (w_gnt_b) begin
            req_ready[w_idx_b] = 1'b1;
        end
    end

    // Count valid requesters for the contention statistic.
    always_comb begin
        w_vcnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_vcnt = w_vcnt + {3'b000, req_valid[k]};
        end
    end

    assign w_contended = (w_vcnt > 4'd2) && !flush;

    assign w_tag_a  = req_tag [int'(w_idx_a)*TAG_W  +: TAG_W];
    assign w_tag_b  = req_tag [int'(w_idx_b)*TAG_W  +: TAG_W];
    assign w_dest_a = req_dest[int'(w_idx_a)*DEST_W +: DEST_W];
    assign w_dest_b = req_dest[int'(w_idx_b)*DEST_W +: DEST_W];
    assign w_data_a = req_data[int'(w_idx_a)*DATA_W +: DATA_W];
    assign w_data_b = req_data[int'(w_idx_b)*DATA_W +: DATA_W];

    // Register granted results onto the write ports and advance priority past the last grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr       <= '0;
            wb0_en         <= 1'b0;
            wb0_tag        <= '0;
            wb0_dest       <= '0;
            wb0_data       <= '0;
            wb1_en         <= 1'b0;
            wb1_tag        <= '0;
            wb1_dest       <= '0;
            wb1_data       <= '0;
            contention_cnt <= '0;
            err_dup_tag    <= 1'b0;
        end else begin
            wb0_en   <= w_gnt_a;
            wb0_tag  <= w_gnt_a ? w_tag_a  : '0;
            wb0_dest <= w_gnt_a ? w_dest_a : '0;
            wb0_data <= w_gnt_a ? w_data_a : '0;
            wb1_en   <= w_gnt_b;
            wb1_tag  <= w_gnt_b ? w_tag_b  : '0;
            wb1_dest <= w_gnt_b ? w_dest_b : '0;
            wb1_data <= w_gnt_b ? w_data_b : '0;
            if (w_gnt_b) begin
                r_rr_ptr <= ({1'b0, w_idx_b} + 1'b1 >= N_IDX) ? '0 : w_idx_b + 1'b1;
            end else if (w_gnt_a) begin
                r_rr_ptr <= ({1'b0, w_idx_a} + 1'b1 >= N_IDX) ? '0 : w_idx_a + 1'b1;
            end
            if (w_contended && contention_cnt != CNT_MAX) begin
                contention_cnt <= contention_cnt + 1'b1;
            end
            if (w_gnt_a && w_gnt_b && w_tag_a == w_tag_b) begin
                err_dup_tag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// tb/tb_rob_wb_arbiter.sv - randomized and directed checks of rob_wb_arbiter against a behavioural model
module tb_rob_wb_arbiter;
    localparam int N  = 4;
    localparam int TW = 5;
    localparam int DW = 5;
    localparam int XW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             wb_stall;
    logic [N-1:0]     req_valid;
    logic [N*TW-1:0]  req_tag;
    logic [N*DW-1:0]  req_dest;
    logic [N*XW-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic             wb0_en;
    logic [TW-1:0]    wb0_tag;
    logic [DW-1:0]    wb0_dest;
    logic [XW-1:0]    wb0_data;
    logic             wb1_en;
    logic [TW-1:0]    wb1_tag;
    logic [DW-1:0]    wb1_dest;
    logic [XW-1:0]    wb1_data;
    logic [CW-1:0]    contention_cnt;
    logic             err_dup_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int m_rr     = 0;
    int m_cnt    = 0;
    bit m_err    = 0;

    rob_wb_arbiter #(.N_REQ(N), .TAG_W(TW), .DEST_W(DW), .DATA_W(XW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wb_stall(wb_stall),
        .req_valid(req_valid), .req_tag(req_tag), .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready),
        .wb0_en(wb0_en), .wb0_tag(wb0_tag), .wb0_dest(wb0_dest), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_tag(wb1_tag), .wb1_dest(wb1_dest), .wb1_data(wb1_data),
        .contention_cnt(contention_cnt), .err_dup_tag(err_dup_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_unit(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [XW-1:0] x);
        req_valid[i]          = 1'b1;
        req_tag[i*TW +: TW]   = t;
        req_dest[i*DW +: DW]  = d;
        req_data[i*XW +: XW]  = x;
    endtask

    function automatic logic [TW-1:0] utag(input int i);
        return req_tag[i*TW +: TW];
    endfunction
    function automatic logic [DW-1:0] udest(input int i);
        return req_dest[i*DW +: DW];
    endfunction
    function automatic logic [XW-1:0] udata(input int i);
        return req_data[i*XW +: XW];
    endfunction

    // One arbitration cycle: predict grants, check ready, clock, check ports, retire granted units.
    task automatic step();
        int a, b, idx, nv;
        logic [N-1:0] er;
        logic [TW-1:0] ta, tb;
        logic [DW-1:0] da, db;
        logic [XW-1:0] xa, xb;
        a = -1; b = -1; er = '0;
        ta = '0; tb = '0; da = '0; db = '0; xa = '0; xb = '0;
        if (!wb_stall && !flush) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (req_valid[idx]) begin
                    if (a < 0) a = idx;
                    else if (b < 0) b = idx;
                end
            end
        end
        if (a >= 0) begin er[a] = 1'b1; ta = utag(a); da = udest(a); xa = udata(a); end
        if (b >= 0) begin er[b] = 1'b1; tb = utag(b); db = udest(b); xb = udata(b); end
        nv = $countones(req_valid);
        #1;
        chk("ready", req_ready, er);
        @(posedge clk);
        #1;
        if (b >= 0) m_rr = (b + 1) % N;
        else if (a >= 0) m_rr = (a + 1) % N;
        if (nv > 2 && !flush && m_cnt < CMAX) m_cnt++;
        if (a >= 0 && b >= 0 && ta == tb) m_err = 1;
        chk("wb0_en",   wb0_en,   a >= 0);
        chk("wb0_tag",  wb0_tag,  ta);
        chk("wb0_dest", wb0_dest, da);
        chk("wb0_data", wb0_data, xa);
        chk("wb1_en",   wb1_en,   b >= 0);
        chk("wb1_tag",  wb1_tag,  tb);
        chk("wb1_dest", wb1_dest, db);
        chk("wb1_data", wb1_data, xb);
        chk("cnt",      contention_cnt, m_cnt);
        chk("err",      err_dup_tag, m_err);
        if (a >= 0) req_valid[a] = 1'b0;
        if (b >= 0) req_valid[b] = 1'b0;
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_unit(i, TW'($urandom_range(0, 31)), DW'($urandom_range(0, 31)), $urandom);
            end
            wb_stall = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            step();
        end
        wb_stall = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; wb_stall = 1'b0;
        req_valid = '0; req_tag = '0; req_dest = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb0_en", wb0_en, 1'b0);
        chk("rst_wb1_en", wb1_en, 1'b0);
        chk("rst_wb0_tag", wb0_tag, '0);
        chk("rst_cnt", contention_cnt, '0);
        chk("rst_err", err_dup_tag, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: all four valid, tags 3..6
        for (int i = 0; i < N; i++) set_unit(i, TW'(3 + i), DW'(i + 1), 32'h100 + i);
        #1 chk("t1_ready", req_ready, 4'b0011);
        step();
        chk("t1_tag0", wb0_tag, 5'd3);
        chk("t1_tag1", wb1_tag, 5'd4);

        // Test 2: units 2,3 remain
        #1 chk("t2_ready", req_ready, 4'b1100);
        step();
        chk("t2_tag0", wb0_tag, 5'd5);
        chk("t2_tag1", wb1_tag, 5'd6);
        chk("t2_cnt", contention_cnt, 4'd1);

        // Test 3: move pointer to 3, then lone unit 1
        set_unit(2, 5'd20, 5'd2, 32'h2);
        step();
        set_unit(1, 5'd9, 5'd17, 32'hDEADBEEF);
        #1 chk("t3_ready", req_ready, 4'b0010);
        step();
        chk("t3_en0", wb0_en, 1'b1);
        chk("t3_data0", wb0_data, 32'hDEADBEEF);
        chk("t3_en1", wb1_en, 1'b0);

        // Test 4: stall three cycles with units 0,2 valid
        set_unit(0, 5'd1, 5'd1, 32'h11);
        set_unit(2, 5'd2, 5'd2, 32'h22);
        wb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t4_stall_ready", req_ready, 4'b0000);
            step();
            chk("t4_stall_en0", wb0_en, 1'b0);
        end
        wb_stall = 1'b0;
        #1 chk("t4_rel_ready", req_ready, 4'b0101);
        step();
        chk("t4_tag0", wb0_tag, 5'd2);
        chk("t4_tag1", wb1_tag, 5'd1);

        // Test 5: flush with three valid
        set_unit(0, 5'd10, 5'd3, 32'h33);
        set_unit(1, 5'd11, 5'd4, 32'h44);
        set_unit(3, 5'd12, 5'd5, 32'h55);
        flush = 1'b1;
        #1 chk("t5_ready", req_ready, 4'b0000);
        step();
        chk("t5_en0", wb0_en, 1'b0);
        chk("t5_cnt", contention_cnt, 4'd1);
        flush = 1'b0;
        step();
        chk("t5_after_tag0", wb0_tag, 5'd11);
        chk("t5_after_tag1", wb1_tag, 5'd12);
        step();

        // Test 6: duplicate tags on a double grant
        set_unit(0, 5'd7, 5'd6, 32'h66);
        set_unit(1, 5'd7, 5'd7, 32'h77);
        #1 chk("t6_ready", req_ready, 4'b0011);
        step();
        chk("t6_err", err_dup_tag, 1'b1);
        step();
        chk("t6_err_sticky", err_dup_tag, 1'b1);

        rand_cycles(1500);

        // Counter saturation: all units held valid under stall
        for (int i = 0; i < N; i++) if (!req_valid[i]) set_unit(i, TW'(i), DW'(i), 32'(i));
        wb_stall = 1'b1;
        repeat (20) step();
        chk("sat_cnt", contention_cnt, 4'd15);
        wb_stall = 1'b0;

        // Mid-operation reset with a pending write on the ports
        step();
        #2 rst = 1'b0;
        #1;
        chk("mrst_en0", wb0_en, 1'b0);
        chk("mrst_en1", wb1_en, 1'b0);
        chk("mrst_tag0", wb0_tag, '0);
        chk("mrst_cnt", contention_cnt, '0);
        chk("mrst_err", err_dup_tag, 1'b0);
        req_valid = '0;
        m_rr = 0; m_cnt = 0; m_err = 0;
        @(negedge clk);
        rst = 1'b1;
        rand_cycles(400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
